// File: rtl/mat_job_ctrl.sv
// UART frame sequencer for the 2x2 matrix multiplier: parses A/B operand frames, waits MUL_LATENCY, streams 6-byte result.
// Result header appears MUL_LATENCY+1 cycles after the last B byte; tx_byte holds while tx_ready is low, rx bytes while busy are dropped with err.
module mat_job_ctrl #(
    parameter int MUL_LATENCY    = 2,
    parameter int TIMEOUT_CYCLES = 1_200_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] mat_a,
    output logic [31:0] mat_b,
    input  logic [31:0] mat_c,
    output logic [7:0]  job_id,
    output logic        busy,
    output logic        err
);
    localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LIMIT = GW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_JOB, S_DATA, S_COMPUTE, S_SEND
    } state_t;

    state_t        state_q, state_d;
    logic          sel_b_q, sel_b_d;
    logic          a_valid_q, a_valid_d;
    logic [1:0]    idx_q, idx_d;
    logic [2:0]    snd_q, snd_d;
    logic [CW-1:0] lat_q, lat_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [31:0]   mat_a_q, mat_a_d;
    logic [31:0]   mat_b_q, mat_b_d;
    logic [31:0]   res_q, res_d;
    logic [7:0]    job_q, job_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          tx_valid_q, tx_valid_d;
    logic          err_q, err_d;

    logic in_frame;
    logic in_busy;
    logic timed_out;

    function automatic logic [7:0] result_byte(input logic [2:0] n, input logic [31:0] r,
                                               input logic [7:0] j);
        case (n)
            3'd1:    result_byte = j;
            3'd2:    result_byte = r[31:24];
            3'd3:    result_byte = r[23:16];
            3'd4:    result_byte = r[15:8];
            default: result_byte = r[7:0];
        endcase
    endfunction

    assign in_frame  = (state_q == S_SEL) || (state_q == S_JOB) || (state_q == S_DATA);
    assign in_busy   = (state_q == S_COMPUTE) || (state_q == S_SEND);
    // A byte arriving in the same cycle as the limit wins over the timeout.
    assign timed_out = in_frame && !rx_valid && ((gap_q + GW'(1)) == GAP_LIMIT);

    always_comb begin
        state_d    = state_q;
        sel_b_d    = sel_b_q;
        a_valid_d  = a_valid_q;
        idx_d      = idx_q;
        snd_d      = snd_q;
        lat_d      = lat_q;
        gap_d      = '0;
        mat_a_d    = mat_a_q;
        mat_b_d    = mat_b_q;
        res_d      = res_q;
        job_d      = job_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = tx_valid_q;
        err_d      = 1'b0;

        if (in_frame && !rx_valid) gap_d = gap_q + GW'(1);

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_byte == 8'hFF) state_d = S_SEL;
            end
            S_SEL: begin
                if (rx_valid) begin
                    if (rx_byte == 8'h00 || rx_byte == 8'h01) begin
                        sel_b_d = rx_byte[0];
                        state_d = S_JOB;
                    end else if (rx_byte != 8'hFF) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_JOB: begin
                if (rx_valid) begin
                    if (!sel_b_q) begin
                        job_d     = rx_byte;
                        a_valid_d = 1'b0;
                        idx_d     = '0;
                        state_d   = S_DATA;
                    end else if (a_valid_q && rx_byte == job_q) begin
                        idx_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    if (sel_b_q) mat_b_d[{~idx_q, 3'b000} +: 8] = rx_byte;
                    else         mat_a_d[{~idx_q, 3'b000} +: 8] = rx_byte;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (sel_b_q) begin
                            lat_d   = CW'(MUL_LATENCY - 1);
                            state_d = S_COMPUTE;
                        end else begin
                            a_valid_d = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end
                end
            end
            S_COMPUTE: begin
                if (lat_q == '0) begin
                    res_d      = mat_c;
                    tx_byte_d  = 8'hFE;
                    tx_valid_d = 1'b1;
                    snd_d      = '0;
                    state_d    = S_SEND;
                end else begin
                    lat_d = lat_q - CW'(1);
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    if (snd_q == 3'd5) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        snd_d     = snd_q + 3'd1;
                        tx_byte_d = result_byte(snd_q + 3'd1, res_q, job_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abandoned partial A keeps a_valid low (cleared at its job byte); partial B bytes stay in mat_b.
        if (timed_out) begin
            err_d   = 1'b1;
            idx_d   = '0;
            state_d = S_IDLE;
        end

        if (in_busy && rx_valid) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sel_b_q    <= 1'b0;
            a_valid_q  <= 1'b0;
            idx_q      <= '0;
            snd_q      <= '0;
            lat_q      <= '0;
            gap_q      <= '0;
            mat_a_q    <= '0;
            mat_b_q    <= '0;
            res_q      <= '0;
            job_q      <= '0;
            tx_byte_q  <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_b_q    <= sel_b_d;
            a_valid_q  <= a_valid_d;
            idx_q      <= idx_d;
            snd_q      <= snd_d;
            lat_q      <= lat_d;
            gap_q      <= gap_d;
            mat_a_q    <= mat_a_d;
            mat_b_q    <= mat_b_d;
            res_q      <= res_d;
            job_q      <= job_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
        end
    end

    // Reset withdraws the offered byte in the same cycle rather than at the next edge.
    assign tx_valid = tx_valid_q & ~rst;
    assign tx_byte  = tx_byte_q;
    assign mat_a    = mat_a_q;
    assign mat_b    = mat_b_q;
    assign job_id   = job_q;
    assign busy     = in_busy;
    assign err      = err_q;

endmodule

// File: tb/tb_mat_job_ctrl.sv
// Bench for mat_job_ctrl: queue-based frame model checked every cycle, plus literal expectations per scenario.
module tb_mat_job_ctrl;
    localparam int LAT = 2;
    localparam int TO  = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] mat_a, mat_b, mat_c;
    logic [7:0]  job_id;
    logic        busy, err;

    int n_checks = 0;
    int n_errors = 0;
    int err_cnt  = 0;
    bit chk_en   = 1'b0;
    bit rdy_slow = 1'b0;
    int rdy_cnt  = 0;
    logic [7:0] tx_log[$];

    mat_job_ctrl #(.MUL_LATENCY(LAT), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mat_a(mat_a), .mat_b(mat_b), .mat_c(mat_c), .job_id(job_id),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] matmul(input logic [31:0] a, input logic [31:0] b);
        logic [15:0] x[4];
        logic [15:0] y[4];
        logic [15:0] c11, c12, c21, c22;
        for (int i = 0; i < 4; i++) begin
            x[i] = {8'h00, a[31-8*i -: 8]};
            y[i] = {8'h00, b[31-8*i -: 8]};
        end
        c11 = x[0]*y[0] + x[1]*y[2];
        c12 = x[0]*y[1] + x[1]*y[3];
        c21 = x[2]*y[0] + x[3]*y[2];
        c22 = x[2]*y[1] + x[3]*y[3];
        return {c11[7:0], c12[7:0], c21[7:0], c22[7:0]};
    endfunction

    // Combinational datapath stand-in.
    assign mat_c = matmul(mat_a, mat_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: frame bytes collected in a queue, result bytes scheduled in a queue.
    logic [7:0]  fb[$];
    logic [7:0]  txq[$];
    bit          m_aok = 1'b0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [7:0]  m_job = '0;
    int          idle = 0;
    bit          m_busy = 1'b0;
    int          comp_left = 0;
    bit          m_err = 1'b0;

    always @(posedge clk) begin
        logic [31:0] prod;
        logic [7:0]  b;
        int          k;
        if (rst) begin
            fb.delete(); txq.delete();
            m_aok = 0; m_a = '0; m_b = '0; m_job = '0;
            idle = 0; m_busy = 0; comp_left = 0; m_err = 0;
        end else begin
            m_err = 0;
            b = rx_byte;
            if (m_busy) begin
                if (rx_valid) m_err = 1;
                if (comp_left > 0) begin
                    comp_left--;
                    if (comp_left == 0) begin
                        prod = matmul(m_a, m_b);
                        txq.delete();
                        txq.push_back(8'hFE); txq.push_back(m_job);
                        txq.push_back(prod[31:24]); txq.push_back(prod[23:16]);
                        txq.push_back(prod[15:8]);  txq.push_back(prod[7:0]);
                    end
                end else if (tx_ready) begin
                    void'(txq.pop_front());
                    if (txq.size() == 0) m_busy = 0;
                end
            end else if (fb.size() == 0) begin
                idle = 0;
                if (rx_valid && b == 8'hFF) fb.push_back(b);
            end else if (rx_valid) begin
                idle = 0;
                if (fb.size() == 1) begin
                    if (b == 8'h00 || b == 8'h01) fb.push_back(b);
                    else if (b != 8'hFF) begin m_err = 1; fb.delete(); end
                end else if (fb.size() == 2) begin
                    if (fb[1] == 8'h00) begin m_job = b; m_aok = 0; fb.push_back(b); end
                    else if (m_aok && b == m_job) fb.push_back(b);
                    else begin m_err = 1; fb.delete(); end
                end else begin
                    k = fb.size() - 3;
                    if (fb[1] == 8'h00) m_a[31-8*k -: 8] = b;
                    else                m_b[31-8*k -: 8] = b;
                    fb.push_back(b);
                    if (fb.size() == 7) begin
                        if (fb[1] == 8'h00) m_aok = 1;
                        else begin m_busy = 1; comp_left = LAT; end
                        fb.delete();
                    end
                end
            end else begin
                idle++;
                if (idle == TO) begin m_err = 1; fb.delete(); idle = 0; end
            end
        end
    end

    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_log.push_back(tx_byte);
        if (chk_en) begin
            check("tx_valid", {31'b0, tx_valid}, {31'b0, (txq.size() > 0) && !rst});
            if (txq.size() > 0 && !rst) check("tx_byte", {24'b0, tx_byte}, {24'b0, txq[0]});
            check("mat_a", mat_a, m_a);
            check("mat_b", mat_b, m_b);
            check("job_id", {24'b0, job_id}, {24'b0, m_job});
            check("busy", {31'b0, busy}, {31'b0, m_busy});
            check("err", {31'b0, err}, {31'b0, m_err});
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            rdy_cnt++;
            tx_ready = rdy_slow ? (rdy_cnt % 4 == 0) : 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] sel, input logic [7:0] job, input logic [31:0] d);
        send_byte(8'hFF); send_byte(sel); send_byte(job);
        for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8]);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin tick(1); n++; end
        check(name, {31'b0, n < 2000}, 32'd1);
        tick(1);
    endtask

    task automatic check_log(input string name, input logic [47:0] exp);
        logic [7:0] act;
        check({name, "_count"}, tx_log.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            act = (i < tx_log.size()) ? tx_log[i] : 8'hXX;
            check($sformatf("%s_byte%0d", name, i), {24'b0, act}, {24'b0, exp[47-8*i -: 8]});
        end
    endtask

    initial begin
        int e0;
        int n;
        rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; tx_ready = 1'b1;
        tick(2);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_tx_byte", {24'b0, tx_byte}, 32'd0);
        check("rst_mat_a", mat_a, 32'd0);
        check("rst_mat_b", mat_b, 32'd0);
        check("rst_job_id", {24'b0, job_id}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b0; chk_en = 1'b1;
        tick(1);

        // Basic A then B
        tx_log.delete();
        send_frame(8'h00, 8'h2A, 32'h01020304);
        send_frame(8'h01, 8'h2A, 32'h05060708);
        check("t1_mat_a", mat_a, 32'h01020304);
        check("t1_mat_b", mat_b, 32'h05060708);
        wait_idle("t1_done");
        check_log("t1", 48'hFE2A13162B32);

        // Wrong B job is rejected, then a matching B computes
        tx_log.delete();
        send_frame(8'h00, 8'h2A, 32'h01020304);
        e0 = err_cnt;
        send_frame(8'h01, 8'h2B, 32'h090A0B0C);
        tick(2);
        check("t2_err", err_cnt - e0, 32'd1);
        check("t2_mat_b", mat_b, 32'h05060708);
        check("t2_notx", tx_log.size(), 32'd0);
        send_frame(8'h01, 8'h2A, 32'h01000001);
        wait_idle("t2_done");
        check_log("t2", 48'hFE2A01020304);

        // Slow transmitter, plus a byte arriving while busy
        tx_log.delete();
        rdy_slow = 1'b1;
        send_frame(8'h00, 8'h2A, 32'h01020304);
        send_frame(8'h01, 8'h2A, 32'h05060708);
        e0 = err_cnt;
        send_byte(8'h55);
        wait_idle("t3_done");
        rdy_slow = 1'b0;
        check("t3_err", err_cnt - e0, 32'd1);
        check_log("t3", 48'hFE2A13162B32);

        // Resync on repeated 0xFF, then bad select
        e0 = err_cnt;
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h00);
        send_byte(8'h07); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
        tick(1);
        check("t4_job", {24'b0, job_id}, 32'h07);
        check("t4_mat_a", mat_a, 32'h10203040);
        check("t4_noerr", err_cnt - e0, 32'd0);
        send_byte(8'hFF); send_byte(8'h05);
        tick(1);
        check("t4_selerr", err_cnt - e0, 32'd1);

        // Timeout on partial A
        send_byte(8'hFF); send_byte(8'h00); send_byte(8'h09); send_byte(8'h11); send_byte(8'h22);
        e0 = err_cnt;
        tick(TO);
        check("t5_before", err_cnt - e0, 32'd0);
        tick(1);
        check("t5_timeout", err_cnt - e0, 32'd1);
        check("t5_mat_a", mat_a, 32'h11223040);
        check("t5_job", {24'b0, job_id}, 32'h09);
        e0 = err_cnt;
        send_frame(8'h01, 8'h09, 32'h01020304);
        tick(2);
        check("t5_noavalid", err_cnt - e0, 32'd1);

        // Reset in the middle of SEND
        send_frame(8'h00, 8'h2A, 32'h01020304);
        tx_log.delete();
        send_frame(8'h01, 8'h2A, 32'h05060708);
        n = 0;
        while (tx_log.size() < 3 && n < 100) begin tick(1); n++; end
        check("t6_reach3", {31'b0, n < 100}, 32'd1);
        rst = 1'b1;
        #2;
        check("t6_txv_now", {31'b0, tx_valid}, 32'd0);
        tick(1);
        rst = 1'b0;
        check("t6_mat_a", mat_a, 32'd0);
        check("t6_mat_b", mat_b, 32'd0);
        check("t6_job", {24'b0, job_id}, 32'd0);
        check("t6_busy", {31'b0, busy}, 32'd0);
        check("t6_log", tx_log.size(), 32'd3);
        e0 = err_cnt;
        send_frame(8'h01, 8'h00, 32'h01020304);
        tick(2);
        check("t6_berr", err_cnt - e0, 32'd1);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule

// File: doc/mat_job_ctrl.md
# mat_job_ctrl

Frame-level controller that sequences the 2x2 8-bit matrix multiplier from the UART byte stream. It parses operand frames, loads the A and B operand registers, and waits a fixed datapath latency. It then captures the product and streams a result frame back to the UART transmitter. It sits between the uart receive/transmit byte interface and the mat_mul datapath, replacing ad-hoc parsing in the top level.

## Interface
Parameters:
- MUL_LATENCY, 2: clock cycles from stable mat_a/mat_b to valid mat_c (>=1).
- TIMEOUT_CYCLES, 1_200_000: maximum idle gap between bytes inside a frame (100 ms at 12 MHz).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- rx_byte  in  8  received byte, valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe, one byte per strobe.
- tx_byte  out  8  byte to transmit.
- tx_valid  out  1  tx_byte valid; held until accepted.
- tx_ready  in  1  transmitter accepts tx_byte this cycle when tx_valid=1.
- mat_a  out  32  {a11,a12,a21,a22}, a11 in [31:24].
- mat_b  out  32  {b11,b12,b21,b22}, same packing.
- mat_c  in  32  {c11,c12,c21,c22} from the datapath, same packing.
- job_id  out  8  job number of the stored A operand.
- busy  out  1  high in COMPUTE and SEND.
- err  out  1  one-cycle error pulse.

## Operation
- Input frame: 0xFF, sel (0x00=A, 0x01=B), job, d0..d3 (row-major 11,12,21,22).
- Output frame, 6 bytes: 0xFE, job, c11, c12, c21, c22.
- Internal a_valid flag marks that a complete A is held.
- IDLE: rx 0xFF -> SEL. Other bytes are dropped silently.
- SEL:
  - 0x00 or 0x01 -> JOB, and the selection is latched.
  - 0xFF -> remain in SEL (resync); no error.
  - Any other byte -> err pulse, then IDLE.
- JOB:
  - For A: job_id <= byte, a_valid <= 0, then DATA.
  - For B: if a_valid and byte == job_id -> DATA. Otherwise -> err pulse, then IDLE; mat_b is unchanged.
- DATA:
  - A 2-bit index selects the operand byte; each byte is written immediately into the selected operand register.
  - 0xFF is ordinary data here.
  - On the 4th byte, index wraps to 0.
  - For A: a_valid <= 1, then IDLE.
  - For B: -> COMPUTE.
- COMPUTE:
  - A down-counter runs for MUL_LATENCY cycles.
  - mat_c is then captured into a result register, and the state goes to SEND.
- SEND:
  - The 6 bytes go out in order under the valid/ready handshake.
  - After the last accept -> IDLE.
  - a_valid stays 1, so further B frames with the same job reuse the stored A.
- rx_valid in COMPUTE or SEND: the byte is discarded with an err pulse. The state is unaffected.
- Timeout:
  - In SEL, JOB and DATA, a gap counter resets on each rx_valid.
  - Reaching TIMEOUT_CYCLES -> err pulse, then IDLE.
  - A partially loaded A leaves a_valid=0. A partially loaded B keeps its partial bytes; no compute follows.
- Arithmetic: the controller performs none. Product bytes are passed through exactly as the datapath truncates them to 8 bits.
- Reset values:
  - tx_byte=0, tx_valid=0, mat_a=0, mat_b=0, job_id=0, busy=0, err=0.
  - a_valid=0, state=IDLE, all counters 0.
- Reset mid-operation (any state, including mid-SEND): all of the above apply on the next edge, and tx_valid drops immediately.

## Timing
- Each state transition takes effect on the edge following the rx_valid cycle. One byte per cycle is sustainable.
- Operand register update: visible the cycle after the accepting rx_valid.
- 4th B byte accepted at cycle t:
  - mat_b is final at t+1.
  - mat_c is captured at the edge ending cycle t+MUL_LATENCY.
  - The first tx_valid (0xFE) is asserted in cycle t+MUL_LATENCY+1.
- TX handshake:
  - tx_byte must be stable while tx_valid=1 and tx_ready=0.
  - A transfer occurs when both are 1. The next byte is presented in the following cycle with tx_valid still high (back-to-back allowed).
  - tx_valid drops the cycle after the 6th transfer.
- busy rises with the COMPUTE entry edge and falls with the IDLE entry edge.
- err is exactly 1 cycle per event. Simultaneous timeout and rx_valid: the byte wins and the counter resets.

## Test plan
- A frame FF 00 2A 01 02 03 04, then B frame FF 01 2A 05 06 07 08, tx_ready=1 -> mat_a=0x01020304, mat_b=0x05060708, TX bytes FE 2A 13 16 2B 32; busy falls after the last byte.
- Same sequence with B job 0x2B -> err pulse in the B job cycle, mat_b unchanged, no TX; a following B with job 0x2A computes normally.
- A frame, B frame, with tx_ready toggling 1-in-4 -> tx_byte held stable while stalled; all 6 bytes delivered in order, none duplicated.
- FF FF FF 00 07 10 20 30 40 -> A loaded with job 0x07, no err (resync). FF 05 -> err, IDLE.
- FF 00 09 11 22, then a gap of TIMEOUT_CYCLES (set to 100) -> err at gap cycle 100; a subsequent B with job 0x09 -> err (a_valid=0).
- rst asserted during SEND after 3 bytes -> next cycle tx_valid=0, mat_a=mat_b=0, job_id=0; a B frame with job 0 -> err.
